// File: rtl/lspc_vram_cpu_sched_pkg.sv
// Shared types and helpers for the LSPC CPU-side VRAM scheduler:
// the scheduler state encoding, VRAM address geometry and the auto-increment rule.
package lspc_pkg;

    localparam int VRAM_AW        = 16;
    localparam int VRAM_UPPER_BIT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } sched_state_e;

    // The bank-select bit never moves; only the low field steps by the modulo and wraps.
    function automatic logic [VRAM_AW-1:0] vram_addr_incr(
        input logic [VRAM_AW-1:0] addr,
        input logic [VRAM_AW-1:0] modulo
    );
        return {addr[VRAM_UPPER_BIT],
                addr[VRAM_UPPER_BIT-1:0] + modulo[VRAM_UPPER_BIT-1:0]};
    endfunction

endpackage

// File: rtl/lspc_vram_cpu_sched_if.sv
// Bus bundle between the LSPC register decode / timing generator / VRAM port mux
// and the CPU VRAM scheduler.
interface lspc_vram_cpu_sched_if;
    import lspc_pkg::*;

    logic               ADDR_WR;
    logic               MOD_WR;
    logic               DATA_WR;
    logic [VRAM_AW-1:0] CPU_DATA;
    logic               SLOT_GRANT;
    logic [15:0]        VRAM_RDATA;

    logic [VRAM_AW-1:0] VRAM_ADDR;
    logic [15:0]        VRAM_WDATA;
    logic               VRAM_nWE;
    logic               VRAM_OWN;
    logic [VRAM_AW-1:0] REG_VRAMADDR;
    logic [VRAM_AW-1:0] REG_VRAMMOD;
    logic [15:0]        RD_LATCH;
    logic               nWRITE_PEND;
    logic               WRITE_DONE;
    logic               BUSY;

    modport master (
        output ADDR_WR, MOD_WR, DATA_WR, CPU_DATA, SLOT_GRANT, VRAM_RDATA,
        input  VRAM_ADDR, VRAM_WDATA, VRAM_nWE, VRAM_OWN, REG_VRAMADDR,
               REG_VRAMMOD, RD_LATCH, nWRITE_PEND, WRITE_DONE, BUSY
    );

    modport slave (
        input  ADDR_WR, MOD_WR, DATA_WR, CPU_DATA, SLOT_GRANT, VRAM_RDATA,
        output VRAM_ADDR, VRAM_WDATA, VRAM_nWE, VRAM_OWN, REG_VRAMADDR,
               REG_VRAMMOD, RD_LATCH, nWRITE_PEND, WRITE_DONE, BUSY
    );

endinterface

// File: rtl/lspc_vram_addr_gen.sv
// VRAM address and modulo registers. A CPU address load always beats the
// post-write auto-increment when both happen in the same cycle.
module lspc_vram_addr_gen
    import lspc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               addr_ld,
    input  logic               mod_ld,
    input  logic [VRAM_AW-1:0] ld_data,
    input  logic               addr_incr,
    output logic [VRAM_AW-1:0] addr_o,
    output logic [VRAM_AW-1:0] mod_o
);

    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_AW-1:0] mod_q,  mod_d;

    // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
    always_comb begin
        addr_d = addr_q;
        mod_d  = mod_q;
        if (addr_ld) begin
            addr_d = ld_data;
        end else if (addr_incr) begin
            addr_d = vram_addr_incr(addr_q, mod_q);
        end
        if (mod_ld) begin
            mod_d = ld_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            mod_q  <= '0;
        end else begin
            addr_q <= addr_d;
            mod_q  <= mod_d;
        end
    end

    assign addr_o = addr_q;
    assign mod_o  = mod_q;

endmodule

// File: rtl/lspc_vram_cpu_sched.sv
// CPU-side VRAM scheduler: holds pending REG_VRAMRW writes and read-latch refreshes
// and plays them onto the VRAM port only inside slots granted by the timing generator.
module lspc_vram_cpu_sched
    import lspc_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int READ_LAT    = 2
)(
    input  logic                  CLK,
    input  logic                  nRESET,
    lspc_vram_cpu_sched_if.slave  bus
);

    localparam int               CW       = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0]    LAST_CYC = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]    RD_CYC   = CW'(READ_LAT);

    sched_state_e       state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        vram_wdata_q, vram_wdata_d;
    logic [VRAM_AW-1:0] slot_addr_q, slot_addr_d;
    logic [15:0]        rd_latch_q, rd_latch_d;
    logic               wr_pend_q, wr_pend_d;
    logic               rd_pend_q, rd_pend_d;
    logic               wr_again_q, wr_again_d;
    logic               addr_reld_q, addr_reld_d;

    logic               addr_incr;
    logic               slot_last;
    logic [VRAM_AW-1:0] reg_addr;
    logic [VRAM_AW-1:0] reg_mod;

    lspc_vram_addr_gen u_addr_gen (
        .clk       (CLK),
        .rst_n     (nRESET),
        .addr_ld   (bus.ADDR_WR),
        .mod_ld    (bus.MOD_WR),
        .ld_data   (bus.CPU_DATA),
        .addr_incr (addr_incr),
        .addr_o    (reg_addr),
        .mod_o     (reg_mod)
    );

    assign slot_last = (cnt_q == LAST_CYC);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wdata_d      = wdata_q;
        vram_wdata_d = vram_wdata_q;
        slot_addr_d  = slot_addr_q;
        rd_latch_d   = rd_latch_q;
        wr_pend_d    = wr_pend_q;
        rd_pend_d    = rd_pend_q;
        wr_again_d   = wr_again_q;
        addr_reld_d  = addr_reld_q;
        addr_incr    = 1'b0;

        if (bus.DATA_WR) wdata_d   = bus.CPU_DATA;
        if (bus.ADDR_WR) rd_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                // A new address cancels a write that has not reached the port yet.
                if (bus.ADDR_WR) wr_pend_d = 1'b0;
                if (bus.DATA_WR) wr_pend_d = 1'b1;
                if (bus.SLOT_GRANT && (wr_pend_d || rd_pend_d)) begin
                    cnt_d       = '0;
                    wr_again_d  = 1'b0;
                    addr_reld_d = 1'b0;
                    slot_addr_d = bus.ADDR_WR ? bus.CPU_DATA : reg_addr;
                    if (wr_pend_d) begin
                        state_d      = WRITE;
                        vram_wdata_d = wdata_d;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.ADDR_WR) begin
                    addr_reld_d = 1'b1;
                    wr_again_d  = 1'b0;
                end
                if (bus.DATA_WR) wr_again_d = 1'b1;
                if (slot_last) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    wr_pend_d = wr_again_d;
                    rd_pend_d = 1'b1;
                    // A mid-slot address load must not be stepped by this write's increment.
                    addr_incr = !addr_reld_q;
                end
            end

            READ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.ADDR_WR) begin
                    wr_pend_d   = 1'b0;
                    addr_reld_d = 1'b1;
                end
                if (bus.DATA_WR) wr_pend_d = 1'b1;
                if (cnt_q == RD_CYC) rd_latch_d = bus.VRAM_RDATA;
                if (slot_last) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    rd_pend_d = addr_reld_d;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wdata_q      <= '0;
            vram_wdata_q <= '0;
            slot_addr_q  <= '0;
            rd_latch_q   <= '0;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            wr_again_q   <= 1'b0;
            addr_reld_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            vram_wdata_q <= vram_wdata_d;
            slot_addr_q  <= slot_addr_d;
            rd_latch_q   <= rd_latch_d;
            wr_pend_q    <= wr_pend_d;
            rd_pend_q    <= rd_pend_d;
            wr_again_q   <= wr_again_d;
            addr_reld_q  <= addr_reld_d;
        end
    end

    // The strobe is kept off the first and last slot cycles to give address setup and hold.
    assign bus.VRAM_nWE     = !((state_q == WRITE) && (cnt_q != '0) && !slot_last);
    assign bus.VRAM_OWN     = (state_q != IDLE);
    assign bus.VRAM_ADDR    = (state_q != IDLE) ? slot_addr_q : '0;
    assign bus.VRAM_WDATA   = vram_wdata_q;
    assign bus.REG_VRAMADDR = reg_addr;
    assign bus.REG_VRAMMOD  = reg_mod;
    assign bus.RD_LATCH     = rd_latch_q;
    assign bus.nWRITE_PEND  = !wr_pend_q;
    assign bus.WRITE_DONE   = (state_q == WRITE) && slot_last;
    assign bus.BUSY         = (state_q != IDLE);

endmodule
